// File: rtl/iterative_divider.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per clock.
// A single ripple-carry adder, used as a subtractor, forms the trial difference.

module ripple_carry_adder #(
   parameter int unsigned WIDTH = 33
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Per-bit full adders; each stage owns its carry so the chain stays acyclic
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic c_in;
      logic c_out;
      if (i == 0) begin : g_first
         assign c_in = cin;
      end else begin : g_chain
         assign c_in = g_bit[i-1].c_out;
      end
      assign sum[i] = a[i] ^ b[i] ^ c_in;
      assign c_out  = (a[i] & b[i]) | (a[i] & c_in) | (b[i] & c_in);
   end

   assign cout = g_bit[WIDTH-1].c_out;

endmodule

module iterative_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int unsigned RW = WIDTH + 1;

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_run  = 2'd1,
      st_done = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH-1:0] q_reg;
   logic [RW-1:0]    r_reg;
   logic             dbz_pend;

   logic [RW-1:0]    r_shift;
   logic [RW-1:0]    d_inv;
   logic [RW-1:0]    diff;
   logic             no_borrow;
   logic             accept;
   logic             zero_div;

   assign r_shift  = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
   assign d_inv    = ~{1'b0, d_reg};
   assign accept   = start & ~busy;
   assign zero_div = (divisor == '0);

   // Trial subtraction r_shift - d: carry out set means no borrow
   ripple_carry_adder #(
      .WIDTH (RW)
   ) u_sub (
      .a    (r_shift),
      .b    (d_inv),
      .cin  (1'b1),
      .sum  (diff),
      .cout (no_borrow)
   );

   // busy mirrors st_run exactly, so acceptance is possible in both IDLE and DONE
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= st_idle;
         count       <= '0;
         d_reg       <= '0;
         q_reg       <= '0;
         r_reg       <= '0;
         dbz_pend    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;

         case (state)
            st_idle: begin
               state <= st_idle;
            end
            st_run: begin
               q_reg <= {q_reg[WIDTH-2:0], no_borrow};
               r_reg <= no_borrow ? diff : r_shift;
               if (count == '0) begin
                  state <= st_done;
                  busy  <= 1'b0;
               end else begin
                  count <= count - 1'b1;
               end
            end
            st_done: begin
               state       <= st_idle;
               done        <= 1'b1;
               quotient    <= q_reg;
               remainder   <= r_reg[WIDTH-1:0];
               div_by_zero <= dbz_pend;
            end
            default: begin
               state <= st_idle;
               busy  <= 1'b0;
            end
         endcase

         // Divide by zero preloads the final result and goes straight to DONE
         if (accept) begin
            d_reg    <= divisor;
            count    <= CW'(WIDTH - 1);
            dbz_pend <= zero_div;
            if (zero_div) begin
               q_reg <= '1;
               r_reg <= {1'b0, dividend};
               state <= st_done;
               busy  <= 1'b0;
            end else begin
               q_reg <= dividend;
               r_reg <= '0;
               state <= st_run;
               busy  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed self-checking bench for iterative_divider (WIDTH=32).

module tb_iterative_divider;

   localparam int unsigned W = 32;

   logic         clk;
   logic         reset_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_checks;
   int n_errors;

   iterative_divider #(
      .WIDTH (W)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Start one division, wait for done, check latency, results and the one-cycle pulse
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic exp_dbz, input logic exp_busy, input int exp_lat);
      int   cnt;
      logic saw_busy;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      cnt      = 1;
      saw_busy = busy;
      while (!done && cnt < 200) begin
         @(negedge clk);
         cnt++;
         saw_busy |= busy;
      end
      check({tag, " latency"}, 32'(cnt - 1), 32'(exp_lat));
      check({tag, " quotient"}, quotient, exp_q);
      check({tag, " remainder"}, remainder, exp_r);
      check({tag, " dbz"}, 32'(div_by_zero), 32'(exp_dbz));
      check({tag, " busy seen"}, 32'(saw_busy), 32'(exp_busy));
      @(negedge clk);
      check({tag, " done pulse"}, 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      check({tag, " q held"}, quotient, exp_q);
   endtask

   initial begin
      int cnt;
      int pulses;
      n_checks = 0;
      n_errors = 0;
      reset_n  = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst quotient", quotient, 32'd0);
      check("rst remainder", remainder, 32'd0);
      check("rst dbz", 32'(div_by_zero), 32'd0);
      reset_n = 1'b1;

      run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, 33);
      run_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 33);
      run_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 33);
      run_div("5/10", 32'd5, 32'd10, 32'd0, 32'd5, 1'b0, 1'b1, 33);
      run_div("msb/3", 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0, 1'b1, 33);
      run_div("1234/0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b0, 1);
      run_div("1e6/1000", 32'd1000000, 32'd1000, 32'd1000, 32'd0, 1'b0, 1'b1, 33);
      run_div("beef/16", 32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF, 1'b0, 1'b1, 33);

      // Ignored start while busy, then back-to-back start in the DONE cycle
      @(negedge clk);
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt   = 1;
      while (cnt < 33) begin
         if (cnt == 10) begin
            dividend = 32'd9;
            divisor  = 32'd3;
            start    = 1'b1;
         end else if (cnt == 11) begin
            start = 1'b0;
         end
         @(negedge clk);
         cnt++;
      end
      check("b2b done early", 32'(done), 32'd0);
      dividend = 32'd9;
      divisor  = 32'd3;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b first done", 32'(done), 32'd1);
      check("b2b first quotient", quotient, 32'd14);
      check("b2b first remainder", remainder, 32'd2);
      check("b2b restarted busy", 32'(busy), 32'd1);
      cnt = 1;
      @(negedge clk);
      while (!done && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      check("b2b second latency", 32'(cnt), 32'd33);
      check("b2b second quotient", quotient, 32'd3);
      check("b2b second remainder", remainder, 32'd0);

      // Reset in the middle of a run discards it
      @(negedge clk);
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      check("midrst quotient", quotient, 32'd0);
      check("midrst remainder", remainder, 32'd0);
      check("midrst dbz", 32'(div_by_zero), 32'd0);
      reset_n = 1'b1;
      pulses  = 0;
      repeat (45) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("midrst no done", 32'(pulses), 32'd0);
      run_div("fresh 100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, 33);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
